int4_dot_accumulator: RTL and testbench
=======================================

Name: int4_dot_accumulator

Overview:
Downstream consumer of the INT4 pack/unpack stage.
- Accepts one 16-bit packed word of 4 INT4 weights per beat, plus 4 INT8 activations.
- Computes the 4-lane dot product and accumulates it over a vector of beats terminated by `in_last`.
- Presents the final sum on a valid/ready output.
- Lanes with a zero weight are gated (multiplier not toggled), exploiting the per-lane zero mask.

Parameters:
- ACC_W, 32, accumulator and result width in bits (minimum 16).
- MAX_LEN, 256, maximum beats per vector before forced termination.
- CNT_W, $clog2(MAX_LEN+1), beat counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w_signed  in  1  1 = weight nibbles are two's complement [-8,7]; 0 = unsigned [0,15]. Sampled per beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_w_packed  in  16  weights; lane k = bits [4k+3:4k].
- in_act  in  32  signed INT8 activations; lane k = bits [8k+7:8k].
- in_last  in  1  final beat of the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  ACC_W  signed dot-product sum.
- out_count  out  CNT_W  number of beats accumulated into out_result.
- out_trunc  out  1  vector was force-terminated at MAX_LEN without `in_last`.

Behaviour:
- Reset:
  - State goes to ACCUM.
  - Accumulator, beat counter, out_result, out_count and out_trunc are all 0.
  - out_valid is 0; in_ready is 1 on the first cycle after reset.
- Arithmetic per lane:
  - Weight is sign- or zero-extended to 5 bits per `w_signed`.
  - The 5b x 8b signed product is 13 bits.
  - The four products sum to 15 bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- Zero gating: a lane whose weight nibble is 0 contributes exactly 0, and its product input is held. Result is bit-identical to ungated.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready = 1 and out_valid = 0.
  - On a beat (in_valid & in_ready): acc += beat_dot and count += 1.
  - If in_last, or count+1 == MAX_LEN:
    - out_result <= acc + beat_dot and out_count <= count + 1.
    - out_trunc <= (!in_last).
    - acc and count are cleared; next state is HOLD.
- HOLD:
  - in_ready = 0 and out_valid = 1.
  - Outputs are stable until out_ready.
  - On out_ready, next state is ACCUM and out_valid drops the following cycle.
  - No bypass: at least one bubble cycle separates vectors.
- Latency: out_valid asserts the cycle after the final beat is accepted.
- Single-beat vector (in_last on the first beat): out_count = 1.
- in_valid with no beat accepted (in HOLD): no state change; the input must be held by the sender.
- Reset mid-vector or in HOLD: partial sum is discarded, the result is dropped, and the block returns to reset values.
- out_ready while in ACCUM: ignored.

Optional Feature:
- Macro: INT4_DOT_ZSTAT_EN.
- When defined:
  - Adds output `out_zero_lanes [CNT_W+1:0]`, the count of zero-weight lanes across the vector.
  - It is latched alongside out_result, reset to 0, and valid with out_valid.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared include `int4_dot_defs.vh`:
  - State encodings (ACCUM = 1'b0, HOLD = 1'b1).
  - Lane count (4), INT4 width (4), activation width (8), lane product width (13).
- Sub-module `int4_lane_dot`:
  - Purely combinational 4-lane extend/multiply/sum with zero gating.
  - Outputs a 15-bit signed dot and a 4-bit zero mask.
  - Instantiated once.

Test Plan:
- Unsigned sum: w_signed=0, in_w_packed=16'h1234, all act=1, single beat with last -> out_result=10, out_count=1, out_trunc=0 one cycle later.
- Signed vs unsigned: in_w_packed=16'hF8F8, all act=127, single beat.
  - w_signed=1 -> out_result=-2286.
  - Repeat with w_signed=0 -> out_result=5842.
- Multi-beat with backpressure:
  - 3 beats of w=16'h1111, act=2 each; last on beat 3 -> out_result=24, out_count=3.
  - Hold out_ready=0 for 5 cycles -> in_ready=0 and outputs stable throughout.
- Truncation: MAX_LEN=4, 4 beats w=16'h0001, act lane0=-1, no last -> out_result=-4, out_count=4, out_trunc=1. Next vector starts from 0.
- Zero lanes and wrap (ACC_W=16):
  - w=16'h0000 -> contribution 0; with ZSTAT_EN, out_zero_lanes=4.
  - 300 beats of w=16'h7777, act=127 -> out_result = (300*3556) mod 2^16 as signed, with no saturation.
- Reset mid-vector: 2 beats accepted, rst for 1 cycle, then 1-beat vector w=16'h0001, act=5 -> out_result=5, out_count=1.

Source files
------------

// File: rtl/int4_dot_accumulator_pkg.sv
// Shared definitions for the INT4 dot-product accumulator: FSM encoding,
// lane geometry and a small popcount helper.
package int4_dot_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int LANES  = 4;
  localparam int W_W    = 4;   // INT4 weight nibble
  localparam int ACT_W  = 8;   // INT8 activation
  localparam int PROD_W = 13;  // 5b x 8b signed product
  localparam int DOT_W  = 15;  // sum of four lane products

  function automatic logic [2:0] popcount4(input logic [LANES-1:0] m);
    popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/int4_lane_dot.sv
// Combinational 4-lane INT4 x INT8 dot product with per-lane zero gating.
// A zero-weight lane forces both multiplier operands to 0 so it never toggles.
module int4_lane_dot
  import int4_dot_accumulator_pkg::*;
(
  input  logic                      w_signed,
  input  logic [LANES*W_W-1:0]      w_packed,
  input  logic [LANES*ACT_W-1:0]    act,
  output logic signed [DOT_W-1:0]   dot,
  output logic [LANES-1:0]          zero_mask
);

  logic signed [PROD_W-1:0] prod [LANES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W_W-1:0]          w_nib;
      logic signed [W_W:0]     w_ext;
      logic signed [ACT_W-1:0] a_op;

      assign w_nib         = w_packed[gi*W_W +: W_W];
      assign zero_mask[gi] = (w_nib == '0);
      assign w_ext         = zero_mask[gi] ? '0 : {w_signed & w_nib[W_W-1], w_nib};
      assign a_op          = zero_mask[gi] ? '0 : act[gi*ACT_W +: ACT_W];
      assign prod[gi]      = PROD_W'(w_ext) * PROD_W'(a_op);
    end
  endgenerate

  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + DOT_W'(prod[i]);
    end
  end

endmodule

// File: rtl/int4_dot_accumulator.sv
// Accumulates 4-lane INT4 x INT8 dot products over a vector and presents the
// sum on a valid/ready output. Optional zero-lane statistics: INT4_DOT_ZSTAT_EN.
module int4_dot_accumulator
  import int4_dot_accumulator_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_signed,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_w_packed,
  input  logic [31:0]             in_act,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_result,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_trunc
`ifdef INT4_DOT_ZSTAT_EN
  ,
  output logic [CNT_W+1:0]        out_zero_lanes
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_t                  state_reg, state_next;
  logic [ACC_W-1:0]        acc_reg, acc_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [ACC_W-1:0]        out_result_reg;
  logic [CNT_W-1:0]        out_count_reg;
  logic                    out_trunc_reg;
  logic signed [DOT_W-1:0] beat_dot;
  logic [LANES-1:0]        zero_mask;
  logic                    beat;
  logic                    close_vec;

  int4_lane_dot u_lane_dot (
    .w_signed  (w_signed),
    .w_packed  (in_w_packed),
    .act       (in_act),
    .dot       (beat_dot),
    .zero_mask (zero_mask)
  );

  // An all-gated beat contributes nothing, so the accumulator adder is bypassed.
  assign beat       = in_valid && in_ready;
  assign acc_next   = (&zero_mask) ? acc_reg : acc_reg + ACC_W'(beat_dot);
  assign count_next = count_reg + CNT_W'(1);
  assign close_vec  = beat && (in_last || (count_next == MAX_CNT));

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready = 1'b1;
        if (close_vec) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ACCUM;
      acc_reg        <= '0;
      count_reg      <= '0;
      out_result_reg <= '0;
      out_count_reg  <= '0;
      out_trunc_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (beat) begin
        if (close_vec) begin
          out_result_reg <= acc_next;
          out_count_reg  <= count_next;
          out_trunc_reg  <= !in_last;
          acc_reg        <= '0;
          count_reg      <= '0;
        end else begin
          acc_reg   <= acc_next;
          count_reg <= count_next;
        end
      end
    end
  end

  assign out_result = out_result_reg;
  assign out_count  = out_count_reg;
  assign out_trunc  = out_trunc_reg;

`ifdef INT4_DOT_ZSTAT_EN
  logic [CNT_W+1:0] zero_acc_reg, zero_acc_next;
  logic [CNT_W+1:0] out_zero_lanes_reg;

  assign zero_acc_next = zero_acc_reg + (CNT_W + 2)'(popcount4(zero_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_acc_reg       <= '0;
      out_zero_lanes_reg <= '0;
    end else if (beat) begin
      if (close_vec) begin
        out_zero_lanes_reg <= zero_acc_next;
        zero_acc_reg       <= '0;
      end else begin
        zero_acc_reg <= zero_acc_next;
      end
    end
  end

  assign out_zero_lanes = out_zero_lanes_reg;
`endif

endmodule

// File: tb/tb_int4_dot_accumulator.sv
// Directed bench for int4_dot_accumulator: three instances (default, 16-bit
// wrapping accumulator, MAX_LEN=4) selected one at a time through sel.
module tb_int4_dot_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, w_signed, in_valid, in_last, out_ready;
  logic [15:0] in_w_packed;
  logic [31:0] in_act;
  int          sel;

  logic               rdy_a, rdy_w, rdy_t, ov_a, ov_w, ov_t, tr_a, tr_w, tr_t;
  logic signed [31:0] res_a, res_t;
  logic signed [15:0] res_w;
  logic [8:0]         cnt_a;
  logic [9:0]         cnt_w;
  logic [2:0]         cnt_t;
  logic [10:0]        zl_a;
  logic [11:0]        zl_w;
  logic [4:0]         zl_t;

  logic        rdy, ov, trunc;
  logic [31:0] res, cnt, zl;

  int errors = 0;
  int checks = 0;

  int4_dot_accumulator u_a (
    .clk(clk), .rst(rst), .w_signed(w_signed),
    .in_valid(in_valid && sel == 0), .in_ready(rdy_a),
    .in_w_packed(in_w_packed), .in_act(in_act), .in_last(in_last),
    .out_valid(ov_a), .out_ready(out_ready && sel == 0),
    .out_result(res_a), .out_count(cnt_a), .out_trunc(tr_a)
`ifdef INT4_DOT_ZSTAT_EN
    , .out_zero_lanes(zl_a)
`endif
  );

  int4_dot_accumulator #(.ACC_W(16), .MAX_LEN(512)) u_w (
    .clk(clk), .rst(rst), .w_signed(w_signed),
    .in_valid(in_valid && sel == 1), .in_ready(rdy_w),
    .in_w_packed(in_w_packed), .in_act(in_act), .in_last(in_last),
    .out_valid(ov_w), .out_ready(out_ready && sel == 1),
    .out_result(res_w), .out_count(cnt_w), .out_trunc(tr_w)
`ifdef INT4_DOT_ZSTAT_EN
    , .out_zero_lanes(zl_w)
`endif
  );

  int4_dot_accumulator #(.ACC_W(32), .MAX_LEN(4)) u_t (
    .clk(clk), .rst(rst), .w_signed(w_signed),
    .in_valid(in_valid && sel == 2), .in_ready(rdy_t),
    .in_w_packed(in_w_packed), .in_act(in_act), .in_last(in_last),
    .out_valid(ov_t), .out_ready(out_ready && sel == 2),
    .out_result(res_t), .out_count(cnt_t), .out_trunc(tr_t)
`ifdef INT4_DOT_ZSTAT_EN
    , .out_zero_lanes(zl_t)
`endif
  );

`ifndef INT4_DOT_ZSTAT_EN
  assign zl_a = '0;
  assign zl_w = '0;
  assign zl_t = '0;
`endif

  always_comb begin
    rdy = rdy_a; ov = ov_a; trunc = tr_a;
    res = 32'(res_a); cnt = 32'(cnt_a); zl = 32'(zl_a);
    if (sel == 1) begin
      rdy = rdy_w; ov = ov_w; trunc = tr_w;
      res = 32'(res_w); cnt = 32'(cnt_w); zl = 32'(zl_w);
    end else if (sel == 2) begin
      rdy = rdy_t; ov = ov_t; trunc = tr_t;
      res = 32'(res_t); cnt = 32'(cnt_t); zl = 32'(zl_t);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got,
               $signed(exp), exp);
    end else begin
      $display("ok   %s: %0d", tag, $signed(got));
    end
  endtask

  // Drives one beat and returns #1 after the edge that accepts it.
  task automatic send_beat(input logic [15:0] w, input logic [31:0] a, input logic last);
    in_w_packed = w;
    in_act      = a;
    in_last     = last;
    in_valid    = 1'b1;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(posedge clk); #1;
    end
    if (!rdy) check("beat_ready_timeout", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Checks the presented result, then accepts it and checks out_valid drops.
  task automatic expect_result(input string tag, input int exp_res, input int exp_cnt,
                               input logic exp_tr, input int exp_zl);
    check({tag, "_valid"}, 32'(ov), 32'd1);
    check({tag, "_result"}, res, 32'(exp_res));
    check({tag, "_count"}, cnt, 32'(exp_cnt));
    check({tag, "_trunc"}, 32'(trunc), 32'(exp_tr));
`ifdef INT4_DOT_ZSTAT_EN
    check({tag, "_zero_lanes"}, zl, 32'(exp_zl));
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(ov), 32'd0);
  endtask

  initial begin
    rst = 1'b1; w_signed = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_w_packed = '0; in_act = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 32'(rdy), 32'd1);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_result", res, 32'd0);
    check("rst_count", cnt, 32'd0);
    check("rst_trunc", 32'(trunc), 32'd0);

    // Unsigned weights 4,3,2,1 times 1
    send_beat(16'h1234, 32'h01010101, 1'b1);
    expect_result("unsigned", 10, 1, 1'b0, 0);

    // -8,-1,-8,-1 signed vs 8,15,8,15 unsigned, times 127
    w_signed = 1'b1;
    send_beat(16'hF8F8, 32'h7F7F7F7F, 1'b1);
    expect_result("signed", -2286, 1, 1'b0, 0);
    w_signed = 1'b0;
    send_beat(16'hF8F8, 32'h7F7F7F7F, 1'b1);
    expect_result("unsigned_f8", 5842, 1, 1'b0, 0);

    // Three beats of 1*2 per lane, then backpressure with a pending input
    for (int b = 0; b < 3; b++) send_beat(16'h1111, 32'h02020202, b == 2);
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", 32'(rdy), 32'd0);
      check("hold_result", res, 32'd24);
      check("hold_count", cnt, 32'd3);
      in_w_packed = 16'hFFFF;
      in_act      = 32'h7F7F7F7F;
      in_valid    = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    expect_result("multi", 24, 3, 1'b0, 0);

    // All-zero weights, then a mixed beat: 2*3 + 1*3 = 9, zero lanes 4 + 2
    send_beat(16'h0000, 32'h7F7F7F7F, 1'b1);
    expect_result("zero_w", 0, 1, 1'b0, 4);
    send_beat(16'h0000, 32'h7F7F7F7F, 1'b0);
    send_beat(16'h0102, 32'h03030303, 1'b1);
    expect_result("zero_mix", 9, 2, 1'b0, 6);

    // Forced termination at MAX_LEN=4, then a fresh vector from zero
    sel = 2;
    #1;
    for (int b = 0; b < 4; b++) send_beat(16'h0001, 32'h000000FF, 1'b0);
    expect_result("trunc", -4, 4, 1'b1, 12);
    send_beat(16'h0001, 32'h00000005, 1'b1);
    expect_result("after_trunc", 5, 1, 1'b0, 3);

    // 300 * 3556 = 1066800 wraps to 18224 in 16 bits
    sel = 1;
    #1;
    for (int b = 0; b < 300; b++) send_beat(16'h7777, 32'h7F7F7F7F, b == 299);
    expect_result("wrap16", 18224, 300, 1'b0, 0);

    // Reset in the middle of a vector discards the partial sum
    sel = 0;
    #1;
    send_beat(16'h1111, 32'h02020202, 1'b0);
    send_beat(16'h1111, 32'h02020202, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(ov), 32'd0);
    check("midrst_in_ready", 32'(rdy), 32'd1);
    check("midrst_result", res, 32'd0);
    check("midrst_count", cnt, 32'd0);
    send_beat(16'h0001, 32'h05050505, 1'b1);
    expect_result("after_rst", 5, 1, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
